// File: rtl/four_way_cl_mul_seq_pkg.sv
// cl_mul_pkg: shared FSM state type and limb/step derivations for the 4-way carry-less multiplier
//   limb_w(n)    limb width L = ceil(n/4)
//   steps(l, d)  digit steps K = ceil(l/d)
package cl_mul_pkg;
    typedef enum logic [1:0] {IDLE, MUL, COMB} state_t;
    function automatic int limb_w(input int n);
        return (n + 3) / 4;
    endfunction
    function automatic int steps(input int l, input int d);
        return (l + d - 1) / d;
    endfunction
endpackage

// File: rtl/four_way_cl_mul_seq_if.sv
// four_way_cl_mul_seq_if: request/result bundle for the carry-less multiplier
//   start, a, b  requester -> multiplier
//   busy, done, c  multiplier -> requester
interface four_way_cl_mul_seq_if #(parameter int N = 521);
    logic start;
    logic [N-1:0] a, b;
    logic busy, done;
    logic [2*N-1:0] c;
    modport master(output start, a, b, input busy, done, c);
    modport slave(input start, a, b, output busy, done, c);
endinterface

// File: rtl/cl_limb_mac.sv
// cl_limb_mac: digit-serial carry-less limb product accumulator, D multiplier bits per step
//   clk, rst  clock, async active-low reset
//   clr       clear accumulator (takes priority over en)
//   en        accumulate the digit selected by cnt
//   cnt       digit index
//   a, b      L-bit limbs, p  2L-1 bit running product
module cl_limb_mac import cl_mul_pkg::*; #(
    parameter int L = 131,
    parameter int D = 8,
    localparam int CW = $clog2(steps(L, D) + 1),
    localparam int W = 2 * L - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] cnt,
    input  logic [L-1:0]  a,
    input  logic [L-1:0]  b,
    output logic [W-1:0]  p
);
    logic [L-1:0] a_sh;
    logic [W-1:0] acc;
    // bits shifted in from beyond the limb are zero, which masks digits past L
    assign a_sh = a >> (int'(cnt) * D);
    always_comb begin
        acc = '0;
        for (int t = 0; t < D; t++)
            if (a_sh[t]) acc ^= W'(b) << (int'(cnt) * D + t);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) p <= '0;
        else if (clr) p <= '0;
        else if (en) p <= p ^ acc;
endmodule

// File: rtl/four_way_cl_mul_seq.sv
// four_way_cl_mul_seq: sequential GF(2)[x] multiplier, 4x4 limb split with digit-serial limb MACs
//   clk  clock, rst  async active-low reset
//   bus  slave side: start/a/b in, busy/done/c out (c = a*b, 2N bits)
module four_way_cl_mul_seq import cl_mul_pkg::*; #(
    parameter int N = 521,
    parameter int D = 8
) (
    input  logic clk,
    input  logic rst,
    four_way_cl_mul_seq_if.slave bus
);
    localparam int L = limb_w(N);
    localparam int K = steps(L, D);
    localparam int CW = $clog2(K + 1);
    localparam int PW = 4 * L;
    localparam int W = 2 * L - 1;
    localparam int SW = 8 * L;
    localparam int CN = 2 * N;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [N-1:0] a_r, b_r;
    logic [PW-1:0] a_pad, b_pad;
    logic [W-1:0] p [16];
    logic [CN-1:0] comb_v, c_r;
    logic done_r, accept, step, last;
    assign a_pad = PW'(a_r);
    assign b_pad = PW'(b_r);
    always_comb begin
        accept = state == IDLE && bus.start;
        step = state == MUL;
        last = step && cnt == CW'(K - 1);
        state_n = accept ? MUL : last ? COMB : state == COMB ? IDLE : state;
    end
    for (genvar g = 0; g < 16; g++) begin : g_mac
        cl_limb_mac #(.L(L), .D(D)) u_mac (
            .clk(clk),
            .rst(rst),
            .clr(accept),
            .en(step),
            .cnt(cnt),
            .a(a_pad[(g / 4) * L +: L]),
            .b(b_pad[(g % 4) * L +: L]),
            .p(p[g])
        );
    end
    // product degree is at most 2N-2, so truncating to 2N bits drops only zeros
    always_comb begin
        comb_v = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                comb_v ^= CN'(SW'(p[4 * i + j]) << ((i + j) * L));
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
            done_r <= 1'b0;
        end else begin
            state <= state_n;
            done_r <= state == COMB;
            cnt <= accept ? '0 : step ? cnt + 1'b1 : cnt;
            if (accept) begin
                a_r <= bus.a;
                b_r <= bus.b;
            end
            if (state == COMB) c_r <= comb_v;
        end
    assign bus.busy = state != IDLE;
    assign bus.done = done_r;
    assign bus.c = c_r;
endmodule

// File: tb/tb_four_way_cl_mul_seq.sv
// tb_four_way_cl_mul_seq: directed checks at defaults plus random checks on a N=17, D=3 instance
module tb_four_way_cl_mul_seq;
    logic clk, rst;
    int checks = 0;
    int errors = 0;
    four_way_cl_mul_seq_if #(.N(521)) bus();
    four_way_cl_mul_seq_if #(.N(17)) bs();
    four_way_cl_mul_seq #(.N(521), .D(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    four_way_cl_mul_seq #(.N(17), .D(3)) dut_s (.clk(clk), .rst(rst), .bus(bs));
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] clmul17(input logic [16:0] x, input logic [16:0] y);
        logic [33:0] r = '0;
        for (int i = 0; i < 17; i++)
            if (x[i]) r ^= 34'(y) << i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [1041:0] obs, input logic [1041:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive start for one edge, then scramble the operands to prove they were captured
    task automatic launch(input logic [520:0] av, input logic [520:0] bv);
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = {av[0], av[520:1]} ^ 521'h5;
        bus.b = {bv[519:0], bv[520]} ^ 521'h3;
    endtask

    task automatic wait_done(input int c0, output int cyc, output int bn);
        cyc = c0;
        bn = 0;
        while (!bus.done && cyc < 40) begin
            bn += int'(bus.busy);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [520:0] av, input logic [520:0] bv, input logic [1041:0] exp);
        int cyc, bn;
        launch(av, bv);
        wait_done(0, cyc, bn);
        check(tag, bus.c, exp);
        check_i({tag, "_lat"}, cyc, 18);
        check_i({tag, "_busy"}, bn, 18);
        check_i({tag, "_busy_at_done"}, int'(bus.busy), 0);
        @(negedge clk);
        check_i({tag, "_pulse"}, int'(bus.done), 0);
        check({tag, "_hold"}, bus.c, exp);
    endtask

    initial begin
        int cyc, bn, dn;
        logic [520:0] av, bv;
        logic [1041:0] e;
        logic [16:0] x, y;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bs.start = 1'b0;
        bs.a = '0;
        bs.b = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_i("rst_busy", int'(bus.busy), 0);
        check_i("rst_done", int'(bus.done), 0);
        check("rst_c", bus.c, '0);
        rst = 1'b1;
        @(negedge clk);

        run("one", 521'd1, 521'd1, 1042'd1);

        av = '0;
        av[520] = 1'b1;
        e = '0;
        e[1040] = 1'b1;
        run("msb", av, av, e);

        av = '1;
        e = '0;
        for (int i = 0; i <= 1040; i += 2) e[i] = 1'b1;
        run("ones", av, av, e);

        av = '0;
        av[130] = 1'b1;
        bv = '0;
        bv[131] = 1'b1;
        e = '0;
        e[261] = 1'b1;
        run("limb_edge", av, bv, e);

        launch(521'd3, 521'd3);
        repeat (4) @(negedge clk);
        bus.a = 521'd7;
        bus.b = 521'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_i("ignored_busy", int'(bus.busy), 1);
        wait_done(5, cyc, bn);
        check("ignored_c", bus.c, 1042'd5);
        check_i("ignored_lat", cyc, 18);
        av = '0;
        av[520] = 1'b1;
        av[0] = 1'b1;
        e = '0;
        e[521] = 1'b1;
        e[520] = 1'b1;
        e[1] = 1'b1;
        e[0] = 1'b1;
        launch(av, 521'd3);
        check_i("b2b_pulse", int'(bus.done), 0);
        check_i("b2b_busy", int'(bus.busy), 1);
        wait_done(0, cyc, bn);
        check("b2b_c", bus.c, e);
        check_i("b2b_lat", cyc, 18);

        av = '0;
        av[130] = 1'b1;
        bv = '0;
        bv[131] = 1'b1;
        launch(av, bv);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check_i("midrst_busy", int'(bus.busy), 0);
        check_i("midrst_done", int'(bus.done), 0);
        check("midrst_c", bus.c, '0);
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            dn += int'(bus.done);
        end
        check_i("midrst_no_done", dn, 0);
        e = '0;
        e[261] = 1'b1;
        run("after_rst", av, bv, e);

        for (int n = 0; n < 1000; n++) begin
            x = n == 0 ? 17'h1ffff : n == 1 ? 17'h10000 : 17'($urandom);
            y = n == 0 ? 17'h1ffff : n == 1 ? 17'h10001 : 17'($urandom);
            bs.a = x;
            bs.b = y;
            bs.start = 1'b1;
            @(negedge clk);
            bs.start = 1'b0;
            bs.a = ~x;
            bs.b = x ^ y;
            cyc = 0;
            while (!bs.done && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("rand_c", 1042'(bs.c), 1042'(clmul17(x, y)));
            check_i("rand_lat", cyc, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/four_way_cl_mul_seq.md
FOUR_WAY_CL_MUL_SEQ -- requirements
Module: four_way_cl_mul_seq

Interface
REQ-001 Parameter N, default 521: operand width in bits; SHALL support N >= 4.
REQ-002 Parameter D, default 8: digit bits processed per cycle per limb product; SHALL support 1 <= D <= L.
REQ-003 Derived values: limb width L = ceil(N/4), here 131; digit-step count K = ceil(L/D), here 17.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to begin a multiplication; sampled only when busy=0.
REQ-007 a  input  N  first GF(2)[x] operand; bit i is the coefficient of x^i.
REQ-008 b  input  N  second GF(2)[x] operand.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when c holds a new result.
REQ-011 c  output  2N  carry-less product a*b over GF(2); bit 2N-1 always 0.

Function
REQ-012 Operands SHALL be zero-padded to 4L bits and split into limbs a0..a3 and b0..b3; limb k is bits [kL+L-1 : kL]; every operand bit, including the MSB, SHALL contribute.
REQ-013 FSM states: IDLE, MUL, COMB.
REQ-014 IDLE with start=1: on that edge, capture a and b into internal registers, clear all 16 limb-product accumulators, clear the digit counter, set busy=1, and go to MUL.
REQ-015 MUL: on each edge, every limb product p_ij, i,j in 0..3, SHALL XOR in (b_j << (cnt*D+t)) for each t in 0..D-1 with a_i[cnt*D+t]=1; digit bits at or beyond L SHALL be treated as 0.
REQ-016 MUL: after step cnt=K-1, go to COMB.
REQ-017 COMB: on one edge, c SHALL receive XOR over k=0..6 of (s_k << kL), where s_k = XOR of p_ij with i+j=k; done=1, busy=0, next state IDLE.
REQ-018 Latency: done SHALL be high exactly K+1 edges after the edge that accepted start; this is 18 cycles at the defaults.
REQ-019 done SHALL be high for exactly one cycle per accepted operation.
REQ-020 c SHALL hold its value from COMB until the next COMB; a/b changes after acceptance SHALL NOT affect the result.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 start=1 in the cycle done=1 SHALL be accepted, giving back-to-back operations.
REQ-023 Each limb-product accumulator SHALL be 2L-1 bits wide; the combine stage SHALL be truncated to 2N bits without loss.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, busy=0, done=0, c=0, and clear the counter and accumulators, including when asserted mid-operation.
REQ-025 After rst deasserts, the first accepted start SHALL produce a correct result with the nominal latency.

Structure
REQ-026 Shared package cl_mul_pkg SHALL hold the FSM state type and the L/K derivation functions.
REQ-027 One sub-module, cl_limb_mac (digit-serial carry-less limb MAC, parameters L and D), SHALL be instantiated 16 times; FSM and combine logic stay in the top.

Verification
REQ-028 Defaults, a=1, b=1 -> c=1; done 18 cycles after start; busy high for those cycles.
REQ-029 Defaults, a=b=2^520 -> only c[1040] set; checks MSB and padding.
REQ-030 Defaults, a=b=all ones -> c has every even bit 0..1040 set and all odd bits 0.
REQ-031 Start asserted again 5 cycles after acceptance, with different operands -> ignored; first result correct; a start on the done cycle is accepted.
REQ-032 rst=0 at cycle 9 of an operation -> outputs 0 immediately, no done pulse; a new operation afterwards is correct.
REQ-033 N=17, D=3 (L=5, K=2), 1000 random operands -> c matches a reference carry-less product; done at 3 cycles.
